// File: rtl/db9_joy_scanner_if.sv
// Result bus of the DB9 scanner: two active-high button words and a per-frame strobe.
interface db9_joy_scanner_if #(
  parameter int NBITS = 16
);
  logic [NBITS-1:0] joy_hi;
  logic [NBITS-1:0] joy_lo;
  logic             frame_valid;

  modport master (output joy_hi, joy_lo, frame_valid);
  modport slave  (input  joy_hi, joy_lo, frame_valid);
endinterface

// File: rtl/db9_joy_scanner.sv
// Drives the DB9 joystick shift chain, deserialises both select phases and
// publishes optionally two-scan-filtered button words once per frame.
module db9_joy_scanner #(
  parameter int CLK_DIV      = 64,
  parameter int NBITS        = 16,
  parameter int SETTLE_TICKS = 8,
  parameter int FILTER       = 1
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic JOY_DATA,
  output logic JOY_CLK,
  output logic JOY_LOAD,
  output logic JOY_SELECT,
  db9_joy_scanner_if.master bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, COMMIT, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    tcnt_q, tcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [NBITS-1:0] prev_hi_q, prev_hi_d, prev_lo_q, prev_lo_d;
  logic             sel_q, sel_d, fv_q, fv_d;
  logic             sync1_q, sync2_q;
  logic             tick, last_bit, settle_done;

  assign tick        = (tcnt_q == CW'(CLK_DIV - 1));
  assign last_bit    = (bcnt_q == BW'(NBITS - 1));
  assign settle_done = (scnt_q == SW'(SETTLE_TICKS - 1));

  // The divider pauses in COMMIT so SETTLE always gets whole ticks.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q != COMMIT) tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      scnt_q    <= '0;
      shift_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prev_hi_q <= '0;
      prev_lo_q <= '0;
      sel_q     <= 1'b1;
      fv_q      <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      scnt_q    <= scnt_d;
      shift_q   <= shift_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prev_hi_q <= prev_hi_d;
      prev_lo_q <= prev_lo_d;
      sel_q     <= sel_d;
      fv_q      <= fv_d;
      sync1_q   <= JOY_DATA;
      sync2_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = LOAD;
      LOAD:    if (tick) state_d = LOW;
      LOW:     if (tick) state_d = last_bit ? COMMIT : HIGH;
      HIGH:    if (tick) state_d = LOW;
      COMMIT:  state_d = SETTLE;
      SETTLE:  if (tick && settle_done) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d    = bcnt_q;
    scnt_d    = scnt_q;
    shift_d   = shift_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prev_hi_d = prev_hi_q;
    prev_lo_d = prev_lo_q;
    sel_d     = sel_q;
    fv_d      = 1'b0;
    case (state_q)
      LOAD: if (tick) bcnt_d = '0;
      // Chain is active-low; MSB arrives first and ends up in bit NBITS-1.
      LOW:  if (tick) shift_d = {shift_q[NBITS-2:0], ~sync2_q};
      HIGH: if (tick) bcnt_d = bcnt_q + 1'b1;
      COMMIT: begin
        if (sel_q) begin
          prev_hi_d = shift_q;
          if (FILTER == 0 || shift_q == prev_hi_q) hi_d = shift_q;
        end else begin
          prev_lo_d = shift_q;
          if (FILTER == 0 || shift_q == prev_lo_q) lo_d = shift_q;
          fv_d = 1'b1;
        end
        sel_d  = ~sel_q;
        scnt_d = '0;
      end
      SETTLE: if (tick && !settle_done) scnt_d = scnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    JOY_CLK         = (state_q == HIGH);
    JOY_LOAD        = (state_q != LOAD);
    JOY_SELECT      = sel_q;
    bus.joy_hi      = hi_q;
    bus.joy_lo      = lo_q;
    bus.frame_valid = fv_q;
  end
endmodule

// File: tb/tb_db9_joy_scanner.sv
// Directed bench: three scanner instances (unfiltered, filtered, full-rate) against a shift-chain model.
module tb_db9_joy_scanner;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] pat_hi = 16'h0000;
  logic [15:0] pat_lo = 16'h0000;
  logic idle_bus = 1'b0;

  logic [15:0] hi [ND];
  logic [15:0] lo [ND];
  logic fv [ND], jclk [ND], jload [ND], jsel [ND];
  int edg [ND], fvc [ND];
  int cyc = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int CD = (g == 2) ? 64 : 4;
    localparam int ST = (g == 2) ? 8 : 2;
    localparam int FL = (g == 0) ? 0 : 1;
    db9_joy_scanner_if #(.NBITS(16)) bus ();
    logic jd, jclk_w, jload_w, jsel_w;
    logic jclk_d = 1'b0;
    logic [15:0] chain = 16'hFFFF;
    int edges = 0, fcnt = 0;

    db9_joy_scanner #(.CLK_DIV(CD), .NBITS(16), .SETTLE_TICKS(ST), .FILTER(FL)) u_dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .JOY_DATA(jd), .JOY_CLK(jclk_w),
      .JOY_LOAD(jload_w), .JOY_SELECT(jsel_w), .bus(bus)
    );

    // Chain model: parallel load of active-low buttons, shift on JOY_CLK rise.
    assign jd = idle_bus ? 1'b1 : chain[15];
    always @(posedge clk) begin
      jclk_d <= jclk_w;
      if (!jload_w) begin
        chain <= ~(jsel_w ? pat_hi : pat_lo);
        edges <= 0;
      end else if (jclk_w && !jclk_d) begin
        chain <= {chain[14:0], 1'b1};
        edges <= edges + 1;
      end
      if (bus.frame_valid) fcnt <= fcnt + 1;
    end

    assign hi[g] = bus.joy_hi;
    assign lo[g] = bus.joy_lo;
    assign fv[g] = bus.frame_valid;
    assign jclk[g] = jclk_w;
    assign jload[g] = jload_w;
    assign jsel[g] = jsel_w;
    assign edg[g] = edges;
    assign fvc[g] = fcnt;
  end

  typedef struct {
    logic [15:0] ph, pl;
    bit          idle;
    logic [15:0] h0, l0, h1, l1;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // kind 0: frame_valid, 1: select low, 2: load low, 3: select low at bit 7
  task automatic wait_ev(input int g, input int kind, input int bound, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      case (kind)
        0: hit = fv[g];
        1: hit = !jsel[g];
        2: hit = !jload[g];
        default: hit = !jsel[g] && edg[g] == 7;
      endcase
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d kind%0d after %0d cycles", g, kind, n);
      n = -1;
    end
  endtask

  task automatic apply(input int i);
    pat_hi = tbl[i].ph;
    pat_lo = tbl[i].pl;
    idle_bus = tbl[i].idle;
  endtask

  function automatic vec_t mk(input logic [15:0] ph, pl, input bit idle,
                              input logic [15:0] h0, l0, h1, l1);
    vec_t v;
    v.ph = ph; v.pl = pl; v.idle = idle;
    v.h0 = h0; v.l0 = l0; v.h1 = h1; v.l1 = l1;
    return v;
  endfunction

  initial begin
    int n, d, last_fv, fc0, t0;
    tbl[0] = mk(16'hA5C3, 16'h0F01, 0, 16'hA5C3, 16'h0F01, 16'h0000, 16'h0000);
    tbl[1] = mk(16'hA5C3, 16'h0F01, 0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01);
    tbl[2] = mk(16'h0001, 16'h0F01, 0, 16'h0001, 16'h0F01, 16'hA5C3, 16'h0F01);
    tbl[3] = mk(16'hA5C3, 16'h0F01, 0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01);
    tbl[4] = mk(16'h0001, 16'h0F01, 0, 16'h0001, 16'h0F01, 16'hA5C3, 16'h0F01);
    tbl[5] = mk(16'h0001, 16'h0F01, 0, 16'h0001, 16'h0F01, 16'h0001, 16'h0F01);
    tbl[6] = mk(16'h0001, 16'h3C3C, 0, 16'h0001, 16'h3C3C, 16'h0001, 16'h0F01);
    tbl[7] = mk(16'h1234, 16'h5678, 1, 16'h0000, 16'h0000, 16'h0001, 16'h0F01);
    for (int i = 8; i < 17; i++)
      tbl[i] = mk(16'h1234, 16'h5678, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[17] = mk(16'hA5C3, 16'h0F01, 0, 16'hA5C3, 16'h0F01, 16'h0000, 16'h0000);
    tbl[18] = mk(16'hA5C3, 16'h0F01, 0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01);

    apply(0);
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("rst_hi%0d", g), 32'(hi[g]), 32'h0);
      chk($sformatf("rst_lo%0d", g), 32'(lo[g]), 32'h0);
      chk($sformatf("rst_fv%0d", g), 32'(fv[g]), 32'h0);
      chk($sformatf("rst_clk%0d", g), 32'(jclk[g]), 32'h0);
      chk($sformatf("rst_load%0d", g), 32'(jload[g]), 32'h1);
      chk($sformatf("rst_sel%0d", g), 32'(jsel[g]), 32'h1);
    end

    @(negedge clk);
    rst_n = 1'b1;
    wait_ev(0, 2, 100, n);
    chk("load_start", n, 4);
    d = 1;
    while (!jload[0] && d < 100) begin
      @(posedge clk);
      #1;
      if (!jload[0]) d++;
    end
    chk("load_len", d, 4);

    last_fv = 0;
    for (int i = 0; i < 19; i++) begin
      wait_ev(0, 1, 1000, n);
      chk($sformatf("v%0d_hi_edges", i), edg[0], 15);
      wait_ev(0, 0, 1000, n);
      chk($sformatf("v%0d_hi0", i), 32'(hi[0]), 32'(tbl[i].h0));
      chk($sformatf("v%0d_lo0", i), 32'(lo[0]), 32'(tbl[i].l0));
      chk($sformatf("v%0d_hi1", i), 32'(hi[1]), 32'(tbl[i].h1));
      chk($sformatf("v%0d_lo1", i), 32'(lo[1]), 32'(tbl[i].l1));
      chk($sformatf("v%0d_lo_edges", i), edg[0], 15);
      if (i > 0) chk($sformatf("v%0d_period", i), cyc - last_fv, 274);
      last_fv = cyc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_fv_pulse", i), 32'(fv[0]), 32'h0);
      chk($sformatf("v%0d_fv_count", i), fvc[0], i + 1);
      if (i < 18) apply(i + 1);
    end

    // Abort in the middle of the lo-phase shift.
    wait_ev(0, 3, 1000, n);
    @(negedge clk);
    rst_n = 1'b0;
    fc0 = fvc[0];
    @(posedge clk);
    #1;
    chk("mid_hi0", 32'(hi[0]), 32'h0);
    chk("mid_lo0", 32'(lo[0]), 32'h0);
    chk("mid_hi1", 32'(hi[1]), 32'h0);
    chk("mid_lo1", 32'(lo[1]), 32'h0);
    chk("mid_sel", 32'(jsel[0]), 32'h1);
    chk("mid_clk", 32'(jclk[0]), 32'h0);
    chk("mid_load", 32'(jload[0]), 32'h1);
    chk("mid_fv", 32'(fv[0]), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ev(0, 0, 1000, n);
    chk("restart_latency", n, 270);
    chk("restart_hi0", 32'(hi[0]), 32'hA5C3);
    chk("restart_lo0", 32'(lo[0]), 32'h0F01);
    @(posedge clk);
    #1;
    chk("restart_fv_count", fvc[0], fc0 + 1);

    // Full-rate instance: frame period.
    wait_ev(2, 0, 12000, n);
    t0 = cyc;
    wait_ev(2, 0, 6000, n);
    chk("period_full", cyc - t0, 5122);
    chk("full_hi", 32'(hi[2]), 32'hA5C3);
    chk("full_lo", 32'(lo[2]), 32'h0F01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
